// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a two-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. IN_READY depends on registered state only.
module if_id_skid_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013),
   parameter int              CNT_W     = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [XLEN-1:0]  IN_INSTR,
   input  logic [XLEN-1:0]  IN_PC,
   input  logic [XLEN-1:0]  IN_PC_PLUS_4,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [XLEN-1:0]  OUT_INSTR,
   output logic [XLEN-1:0]  OUT_PC,
   output logic [XLEN-1:0]  OUT_PC_PLUS_4,
   output logic [CNT_W-1:0] STALL_COUNT
);

   localparam int NF      = 3;
   localparam int F_INSTR = 0;
   localparam int F_PC    = 1;
   localparam int F_PC4   = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_reg;
   logic [XLEN-1:0]  in_field     [NF];
   logic [XLEN-1:0]  bubble_field [NF];
   logic [XLEN-1:0]  m_field_reg  [NF];
   logic [XLEN-1:0]  s_field_reg  [NF];
   logic             m_valid_reg;
   logic             s_valid_reg;
   logic             in_ready_reg;
   logic [CNT_W-1:0] stall_cnt_reg;
   logic             acc;
   logic             drn;

   assign in_field[F_INSTR] = IN_INSTR;
   assign in_field[F_PC]    = IN_PC;
   assign in_field[F_PC4]   = IN_PC_PLUS_4;

   // Bubble contents: NOP in the instruction slot, zero for both PC fields.
   genvar gi;
   generate
      for (gi = 0; gi < NF; gi++) begin : g_bubble
         if (gi == F_INSTR) begin : g_nop
            assign bubble_field[gi] = NOP_INSTR;
         end else begin : g_zero
            assign bubble_field[gi] = '0;
         end
      end
   endgenerate

   assign acc = IN_VALID & in_ready_reg;
   assign drn = m_valid_reg & OUT_READY;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg     <= EMPTY;
         m_field_reg   <= bubble_field;
         s_field_reg   <= bubble_field;
         m_valid_reg   <= 1'b0;
         s_valid_reg   <= 1'b0;
         in_ready_reg  <= 1'b1;
         stall_cnt_reg <= '0;
      end else begin
         // Counts the stalled cycle even when a flush squashes the beat at this edge.
         if (m_valid_reg && !OUT_READY && stall_cnt_reg != CNT_MAX) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end

         if (FLUSH) begin
            state_reg    <= EMPTY;
            m_field_reg  <= bubble_field;
            s_field_reg  <= bubble_field;
            m_valid_reg  <= 1'b0;
            s_valid_reg  <= 1'b0;
            in_ready_reg <= 1'b1;
         end else begin
            case (state_reg)
               EMPTY: begin
                  if (acc) begin
                     state_reg   <= ONE;
                     m_field_reg <= in_field;
                     m_valid_reg <= 1'b1;
                  end
               end
               ONE: begin
                  if (acc && drn) begin
                     m_field_reg <= in_field;
                  end else if (acc) begin
                     state_reg    <= FULL;
                     s_field_reg  <= in_field;
                     s_valid_reg  <= 1'b1;
                     in_ready_reg <= 1'b0;
                  end else if (drn) begin
                     state_reg   <= EMPTY;
                     m_field_reg <= bubble_field;
                     m_valid_reg <= 1'b0;
                  end
               end
               FULL: begin
                  // Skid entry moves up; the front beat has just been taken by ID.
                  if (drn) begin
                     state_reg    <= ONE;
                     m_field_reg  <= s_field_reg;
                     m_valid_reg  <= s_valid_reg;
                     s_valid_reg  <= 1'b0;
                     in_ready_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg    <= EMPTY;
                  m_field_reg  <= bubble_field;
                  s_field_reg  <= bubble_field;
                  m_valid_reg  <= 1'b0;
                  s_valid_reg  <= 1'b0;
                  in_ready_reg <= 1'b1;
               end
            endcase
         end
      end
   end

   assign IN_READY      = in_ready_reg;
   assign OUT_VALID     = m_valid_reg;
   assign OUT_INSTR     = m_field_reg[F_INSTR];
   assign OUT_PC        = m_field_reg[F_PC];
   assign OUT_PC_PLUS_4 = m_field_reg[F_PC4];
   assign STALL_COUNT   = stall_cnt_reg;

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF→ID pipeline stage register that carries INSTRUCTION, PC and PC+4 from the fetch unit to the decoder.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure from ID never creates a combinational path back to IF.
- Adds a synchronous flush that inserts a NOP bubble on branch/jump redirect.
- Adds a saturating stall-cycle counter for performance analysis.

Parameters:
- XLEN, 32, width of instruction, PC and PC+4 fields.
- NOP_INSTR, 32'h00000013 (addi x0,x0,0), bubble instruction driven whenever output is invalid.
- CNT_W, 16, width of stall counter.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous squash of all held and incoming beats.
- IN_VALID  input  1  IF presents a beat.
- IN_READY  output  1  stage can accept a beat this cycle.
- IN_INSTR  input  XLEN  fetched instruction.
- IN_PC  input  XLEN  PC of fetched instruction.
- IN_PC_PLUS_4  input  XLEN  PC+4 of fetched instruction.
- OUT_VALID  output  1  beat presented to ID.
- OUT_READY  input  1  ID accepts the beat.
- OUT_INSTR  output  XLEN  instruction to ID.
- OUT_PC  output  XLEN  PC to ID.
- OUT_PC_PLUS_4  output  XLEN  PC+4 to ID.
- STALL_COUNT  output  CNT_W  cycles with OUT_VALID=1 and OUT_READY=0.

Behaviour:
- Storage: main register M (drives outputs) and skid register S, each holding {instr, pc, pc4} plus a valid bit.
- States: EMPTY (M and S invalid), ONE (M valid, S invalid), FULL (M and S valid).
- IN_READY = (state != FULL). It is a function of registered state only, with no combinational dependence on OUT_READY or FLUSH.
- OUT_VALID = M.valid. Outputs are driven directly from M registers.
- acc = IN_VALID & IN_READY; drn = OUT_VALID & OUT_READY.
- Transitions (no FLUSH):
  - EMPTY: acc → ONE, M ← input. Otherwise stay EMPTY.
  - ONE: acc & drn → ONE, M ← input. acc only → FULL, S ← input. drn only → EMPTY. Neither → hold.
  - FULL: drn → ONE, M ← S, S invalid. Otherwise hold. No acceptance is possible because IN_READY=0.
- Latency: 1 cycle from acceptance to OUT_VALID when EMPTY. Throughput is 1 beat/cycle when OUT_READY is held high.
- Ordering: strict FIFO order is preserved; no beat is duplicated or dropped except by FLUSH.
- Output stability: while OUT_VALID=1 and OUT_READY=0, OUT_* remain unchanged cycle to cycle.
- Invalid M: whenever M is invalid, OUT_INSTR = NOP_INSTR, OUT_PC = 0, OUT_PC_PLUS_4 = 0. Register loads enforce this on every transition into EMPTY.
- FLUSH=1 at an edge:
  - Next state EMPTY; M and S invalidated; M loaded with the bubble values.
  - A beat offered with acc in the same cycle is consumed and discarded; IF treats it as taken.
  - A beat drained in the same cycle counts as delivered.
- Priority: RESET > FLUSH > normal transitions.
- Reset, including mid-operation: next edge gives state EMPTY, IN_READY=1, OUT_VALID=0, OUT_INSTR=NOP_INSTR, OUT_PC=0, OUT_PC_PLUS_4=0, STALL_COUNT=0.
- STALL_COUNT:
  - +1 on every edge where OUT_VALID & ~OUT_READY, before any FLUSH effect.
  - Saturates at 2^CNT_W−1 with no wrap.
  - Cleared only by RESET; FLUSH does not clear it.
- Simultaneous FLUSH and RESET: RESET wins and the counter clears.

Test Plan:
- Reset then stream: RESET 2 cycles, then IN_VALID=1 with instrs 0x00500093, 0x00A00113, 0x002081B3 at PCs 0x0/0x4/0x8 and OUT_READY=1 → OUT_VALID rises 1 cycle after the first beat; 3 consecutive beats in order; IN_READY stays 1; STALL_COUNT=0.
- Back-pressure fill: OUT_READY=0 while offering 3 beats → beats 1 and 2 accepted, IN_READY=0 on the cycle after the 2nd acceptance, 3rd held by IF. OUT_* hold beat 1 and STALL_COUNT increments each cycle. Raising OUT_READY delivers beats 1, 2, 3 in order with no loss.
- Flush with full buffer: state FULL, assert FLUSH 1 cycle → next cycle OUT_VALID=0, OUT_INSTR=0x00000013, OUT_PC=0, IN_READY=1. The next offered beat (PC 0x40) appears alone.
- Flush coincident with acceptance: EMPTY, IN_VALID=1 with PC 0x10 and FLUSH=1 → beat discarded, OUT_VALID stays 0.
- Reset mid-stall: state FULL with STALL_COUNT=5, assert RESET → all outputs at reset values and STALL_COUNT=0. Simultaneous FLUSH is ignored.
- Counter saturation: CNT_W=4, OUT_VALID=1 and OUT_READY=0 for 20 cycles → STALL_COUNT stops at 15.
